// File: rtl/move_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : move_scheduler
// Description : Debounces the keypad held-key code and issues one registered
//               direction code plus a one-cycle move enable per key press.
//               Optional held-key auto-repeat: define MOVE_SCHEDULER_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module move_scheduler #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic       clk_50MHz_i,
  input  logic       rst_async_la_i,
  input  logic       key_valid_i,
  input  logic [3:0] key_code_i,
  output logic [3:0] key_o,
  output logic       enable_move_o,
  output logic [7:0] move_count_o,
  output logic       busy_o
);

`ifdef MOVE_SCHEDULER_REPEAT_EN
  localparam int c_cnt_span = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES
                                                                : REPEAT_CYCLES;
`else
  localparam int c_cnt_span = DEBOUNCE_CYCLES;
`endif
  localparam int c_cnt_w = (c_cnt_span > 1) ? $clog2(c_cnt_span) : 1;
  localparam logic [c_cnt_w-1:0] c_deb_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
`ifdef MOVE_SCHEDULER_REPEAT_EN
  localparam logic [c_cnt_w-1:0] c_rep_last = c_cnt_w'(REPEAT_CYCLES - 1);
`endif
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  localparam logic [3:0] c_key_up    = 4'h2;
  localparam logic [3:0] c_key_right = 4'h6;
  localparam logic [3:0] c_key_down  = 4'h8;
  localparam logic [3:0] c_key_left  = 4'h4;

  generate
    if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
      $error("move_scheduler: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DEBOUNCE = 3'd1,
    S_FIRE     = 3'd2,
    S_HOLD     = 3'd3,
    S_RELEASE  = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_cnt_w-1:0]   w_cnt_nxt;
  logic [3:0]           r_lat;
  logic [3:0]           w_lat_nxt;
  logic [3:0]           r_key;
  logic                 r_enable;
  logic                 r_busy;
  logic [7:0]           r_move_count;
  logic                 w_key_match;
  logic                 w_is_dir;

  assign w_key_match = key_valid_i && (key_code_i == r_lat);
  assign w_is_dir    = (r_lat == c_key_up)   || (r_lat == c_key_right) ||
                       (r_lat == c_key_down) || (r_lat == c_key_left);

  always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
    if (!rst_async_la_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_lat   <= 4'h0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_lat   <= w_lat_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + c_cnt_one;
    w_lat_nxt   = r_lat;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (key_valid_i) begin
          w_lat_nxt   = key_code_i;
          w_state_nxt = S_DEBOUNCE;
        end
      end
      S_DEBOUNCE: begin
        if (!w_key_match) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == c_deb_last) begin
          w_state_nxt = w_is_dir ? S_FIRE : S_HOLD;
        end
      end
      S_FIRE: begin
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        // A different code while held counts as a release of the old key.
        if (!w_key_match) begin
          w_state_nxt = S_RELEASE;
`ifdef MOVE_SCHEDULER_REPEAT_EN
        end else if ((r_cnt == c_rep_last) && w_is_dir) begin
          w_state_nxt = S_FIRE;
`endif
        end
      end
      S_RELEASE: begin
        if (key_valid_i) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == c_deb_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (w_state_nxt != r_state) begin
      w_cnt_nxt = '0;
    end
  end

  // Outputs are decoded from the next state so they align with the state register.
  always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
    if (!rst_async_la_i) begin
      r_key        <= 4'h0;
      r_enable     <= 1'b0;
      r_busy       <= 1'b0;
      r_move_count <= 8'h00;
    end else begin
      r_enable <= (w_state_nxt == S_FIRE);
      r_busy   <= (w_state_nxt != S_IDLE);
      r_key    <= ((w_state_nxt == S_FIRE) || (w_state_nxt == S_HOLD)) ? w_lat_nxt : 4'h0;
      if ((r_state == S_FIRE) && (r_move_count != 8'hFF)) begin
        r_move_count <= r_move_count + 8'h01;
      end
    end
  end

  assign key_o         = r_key;
  assign enable_move_o = r_enable;
  assign busy_o        = r_busy;
  assign move_count_o  = r_move_count;

endmodule
`default_nettype wire
